mesi_bus_controller: RTL

- Snoop-bus controller for the shared-bus MESI lab system: arbitrates N cache controllers, broadcasts the winner's bus message to the per-cache MESI snoop receptors and collects their results.
- Sequences any writeback and memory read that result, then returns completion and the fill state (E or S) to the requester.
- Sits between the cache controllers, the snoop receptors and the single-port main memory.

---
 rtl/mesi_pkg.sv | 34 +++
 rtl/mesi_bus_controller_rr_arbiter.sv | 40 ++++
 rtl/mesi_bus_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mesi_pkg.sv
// Shared encodings for the shared-bus MESI lab system.
// Holds the line-state and bus-message encodings, the bus controller FSM
// state type, and a helper that tells whether a message needs a line read.
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_state_e;

    typedef enum logic [1:0] {
        MSG_RH = 2'b00,
        MSG_RM = 2'b01,
        MSG_WH = 2'b10,
        MSG_WM = 2'b11
    } bus_msg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_SNOOP,
        ST_WB,
        ST_MEM,
        ST_RESP
    } fsm_state_e;

    // Misses (read or write) must fetch the line from main memory.
    function automatic logic msg_needs_mem(input logic [1:0] msg);
        return (msg == MSG_RM) || (msg == MSG_WM);
    endfunction

endpackage

// File: rtl/mesi_bus_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req  - per-requester request vector
//   i_ptr  - index of the highest-priority requester
//   o_gnt  - one-hot grant (zero when no request)
//   o_idx  - index of the granted requester
//   o_any  - at least one request present
module rr_arbiter #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    // Two passes: first from the pointer upward, then wrap from 0 to pointer-1.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_any && (j >= int'(i_ptr)) && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && (j < int'(i_ptr)) && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mesi_bus_controller.sv
// Snoop-bus controller: arbitrates the cache controllers, broadcasts the
// winner's message to the snoop receptors, sequences any writeback and line
// read through the single-port memory, then returns done and fill state.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req/req_msg/req_addr            - per-cache request, message, address
//   gnt/done/fill_shared            - grant, completion pulse, fill S(1)/E(0)
//   bus_valid/bus_msg/bus_addr/bus_src - broadcast to snoop receptors
//   snoop_hit/snoop_wb/snoop_abt    - per-cache receptor results
//   mem_req/mem_we/mem_addr/mem_ack - main memory handshake
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate among pending requests
// ST_BCAST | bus_valid strobe to the receptors
// ST_SNOOP | receptors answer; sample shared / writeback-needed
// ST_WB    | dirty line written back by the owning cache
// ST_MEM   | line read from memory for a miss
// ST_RESP  | done pulse to the requester, release grant, advance pointer
module mesi_bus_controller
    import mesi_pkg::*;
#(
    parameter int N   = 3,
    parameter int AW  = 8,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [2*N-1:0]  req_msg,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            fill_shared,
    output logic            bus_valid,
    output logic [1:0]      bus_msg,
    output logic [AW-1:0]   bus_addr,
    output logic [IDW-1:0]  bus_src,
    input  logic [N-1:0]    snoop_hit,
    input  logic [N-1:0]    snoop_wb,
    input  logic [N-1:0]    snoop_abt,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_ack
);

    fsm_state_e     r_state;
    logic [IDW-1:0] r_ptr;
    logic           r_shared;

    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic [1:0]     w_msg;
    logic [AW-1:0]  w_addr;
    logic           w_shared;
    logic           w_wb_needed;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_msg  = '0;
        w_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == w_idx) begin
                w_msg  = req_msg[2*i +: 2];
                w_addr = req_addr[AW*i +: AW];
            end
        end
    end

    // The requester's own receptor bits are masked out; several writebacks
    // collapse into one since the OR only decides whether a WB phase happens.
    assign w_shared    = |(snoop_hit & ~gnt);
    assign w_wb_needed = |(snoop_wb & snoop_abt & ~gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_shared    <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            fill_shared <= 1'b0;
            bus_valid   <= 1'b0;
            bus_msg     <= 2'b00;
            bus_addr    <= '0;
            bus_src     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            done        <= '0;
            fill_shared <= 1'b0;
            bus_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        gnt      <= w_gnt;
                        bus_src  <= w_idx;
                        bus_msg  <= w_msg;
                        bus_addr <= w_addr;
                        if (w_msg == MSG_RH) begin
                            r_state <= ST_RESP;
                        end else begin
                            bus_valid <= 1'b1;
                            r_state   <= ST_BCAST;
                        end
                    end
                end
                ST_BCAST: r_state <= ST_SNOOP;
                ST_SNOOP: begin
                    r_shared <= w_shared;
                    mem_addr <= bus_addr;
                    if (w_wb_needed) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        r_state <= ST_WB;
                    end else if (msg_needs_mem(bus_msg)) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        // mem_req stays up when the read follows directly.
                        if (msg_needs_mem(bus_msg)) begin
                            r_state <= ST_MEM;
                        end else begin
                            mem_req <= 1'b0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    done        <= gnt;
                    fill_shared <= (bus_msg == MSG_RM) && r_shared;
                    gnt         <= '0;
                    r_ptr       <= (bus_src == IDW'(N-1)) ? '0 : bus_src + 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
